// File: rtl/counter_bank.sv
// Bank of NCH independent down-counters with CPU register access, per-channel
// interrupts and a PWM / pulse output per channel.
module counter_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CHW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter_we,
  input  logic [CHW-1:0]   counter_ch,
  input  logic [1:0]       counter_sel,
  input  logic [31:0]      counter_val,
  input  logic [NCH-1:0]   tick,
  output logic [31:0]      counter_out,
  output logic [NCH-1:0]   counter_irq,
  output logic             irq_any,
  output logic [NCH-1:0]   pwm_out
);

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_ONE   = 2'b01;
  localparam logic [1:0] MODE_PER   = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [WIDTH-1:0] count   [NCH];
  logic [WIDTH-1:0] reload  [NCH];
  logic [WIDTH-1:0] compare [NCH];
  logic [1:0]       mode    [NCH];
  logic [NCH-1:0]   irq_en, run, done;

  logic [NCH-1:0]   wr_hit, wr_cnt, wr_ctl, wr_cmp, evt, step;
  logic [WIDTH-1:0] wval;
  logic [31:0]      rd_data;

  assign wval = counter_val[WIDTH-1:0];

  // evt is the count==1 terminal event (drives done); step is the actual count
  // update, which a concurrent reload or control write suppresses.
  always_comb begin
    wr_hit = '0;
    wr_cnt = '0;
    wr_ctl = '0;
    wr_cmp = '0;
    evt    = '0;
    step   = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = counter_we && (counter_ch == CHW'(i));
      wr_cnt[i] = wr_hit[i] && (counter_sel == 2'b00);
      wr_cmp[i] = wr_hit[i] && (counter_sel == 2'b01);
      wr_ctl[i] = wr_hit[i] && (counter_sel == 2'b10);
      evt[i]    = tick[i] && run[i] && (mode[i] != MODE_STOP) && (count[i] == WIDTH'(1));
      step[i]   = tick[i] && run[i] && (mode[i] != MODE_STOP) && !wr_cnt[i] && !wr_ctl[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        count[i]   <= '0;
        reload[i]  <= '0;
        compare[i] <= '0;
        mode[i]    <= MODE_STOP;
      end
      irq_en      <= '0;
      run         <= '0;
      done        <= '0;
      counter_irq <= '0;
      pwm_out     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_cnt[i]) begin
          reload[i] <= wval;
          count[i]  <= wval;
        end else if (step[i]) begin
          if (count[i] > WIDTH'(1)) begin
            count[i] <= count[i] - WIDTH'(1);
          end else if (count[i] == WIDTH'(1)) begin
            if (mode[i] == MODE_ONE) begin
              count[i] <= '0;
              run[i]   <= 1'b0;
            end else begin
              count[i] <= reload[i];
            end
          end
        end

        if (wr_cmp[i]) compare[i] <= wval;

        if (wr_ctl[i]) begin
          irq_en[i] <= counter_val[3];
          run[i]    <= counter_val[2];
          mode[i]   <= counter_val[1:0];
        end

        // A terminal event beats a simultaneous software clear.
        if (evt[i] && !wr_cnt[i])
          done[i] <= 1'b1;
        else if (wr_ctl[i] && counter_val[4])
          done[i] <= 1'b0;

        counter_irq[i] <= done[i] & irq_en[i];

        case (mode[i])
          MODE_PWM: pwm_out[i] <= (count[i] != '0) && (count[i] <= compare[i]);
          MODE_ONE,
          MODE_PER: pwm_out[i] <= step[i] && (count[i] == WIDTH'(1));
          default:  pwm_out[i] <= 1'b0;
        endcase
      end
    end
  end

  // Out-of-range channels match no entry and read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (counter_ch == CHW'(i)) begin
        case (counter_sel)
          2'b00:   rd_data = 32'(count[i]);
          2'b01:   rd_data = 32'(compare[i]);
          2'b10:   rd_data = {28'b0, irq_en[i], run[i], mode[i]};
          default: rd_data = {31'b0, done[i]};
        endcase
      end
    end
  end

  assign counter_out = rd_data;
  assign irq_any     = |counter_irq;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: a default 4-channel instance plus a
// 3-channel, 8-bit instance for out-of-range channel and width truncation.
module tb_counter_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        counter_we;
  logic [1:0]  counter_ch;
  logic [1:0]  counter_sel;
  logic [31:0] counter_val;
  logic [3:0]  tick;
  logic [31:0] counter_out;
  logic [3:0]  counter_irq;
  logic        irq_any;
  logic [3:0]  pwm_out;

  logic        we_b;
  logic [1:0]  ch_b;
  logic [1:0]  sel_b;
  logic [31:0] val_b;
  logic [2:0]  tick_b;
  logic [31:0] out_b;
  logic [2:0]  irq_b;
  logic        irq_any_b;
  logic [2:0]  pwm_b;

  int n_run  = 0;
  int n_fail = 0;

  counter_bank #(.NCH(4), .WIDTH(32), .CHW(2)) dut (
    .clk(clk), .rst(rst), .counter_we(counter_we), .counter_ch(counter_ch),
    .counter_sel(counter_sel), .counter_val(counter_val), .tick(tick),
    .counter_out(counter_out), .counter_irq(counter_irq), .irq_any(irq_any),
    .pwm_out(pwm_out)
  );

  counter_bank #(.NCH(3), .WIDTH(8), .CHW(2)) dut_b (
    .clk(clk), .rst(rst), .counter_we(we_b), .counter_ch(ch_b),
    .counter_sel(sel_b), .counter_val(val_b), .tick(tick_b),
    .counter_out(out_b), .counter_irq(irq_b), .irq_any(irq_any_b),
    .pwm_out(pwm_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] val);
    counter_we  = 1'b1;
    counter_ch  = ch;
    counter_sel = sel;
    counter_val = val;
    cycle();
    counter_we  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] ch, input logic [1:0] sel,
                        input logic [31:0] exp);
    counter_ch  = ch;
    counter_sel = sel;
    #1;
    check_eq(tag, counter_out, exp);
  endtask

  task automatic wr_b(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] val);
    we_b  = 1'b1;
    ch_b  = ch;
    sel_b = sel;
    val_b = val;
    cycle();
    we_b  = 1'b0;
  endtask

  task automatic rd_chk_b(input string tag, input logic [1:0] ch, input logic [1:0] sel,
                          input logic [31:0] exp);
    ch_b  = ch;
    sel_b = sel;
    #1;
    check_eq(tag, out_b, exp);
  endtask

  initial begin
    int ones;

    // Reset held while a write and ticks are presented: reset must win.
    rst = 1'b0;
    counter_we = 1'b1; counter_ch = 2'd0; counter_sel = 2'b00; counter_val = 32'd7;
    tick = 4'hF;
    we_b = 1'b0; ch_b = 2'd0; sel_b = 2'b00; val_b = 32'd0; tick_b = 3'b000;
    cycle();
    cycle();
    counter_we = 1'b0;
    rd_chk("rst_count0", 2'd0, 2'b00, 32'd0);
    rd_chk("rst_ctrl0", 2'd0, 2'b10, 32'd0);
    check_eq("rst_irq", {28'b0, counter_irq}, 32'd0);
    check_eq("rst_irq_any", {31'b0, irq_any}, 32'd0);
    check_eq("rst_pwm", {28'b0, pwm_out}, 32'd0);
    tick = 4'h0;
    rst  = 1'b1;
    cycle();

    // Ch0 periodic, reload 3, irq enabled.
    wr(2'd0, 2'b00, 32'd3);
    rd_chk("p_count_init", 2'd0, 2'b00, 32'd3);
    wr(2'd0, 2'b10, 32'hE);
    rd_chk("p_ctrl", 2'd0, 2'b10, 32'hE);
    tick = 4'b0001;
    cycle(); rd_chk("p_count_t1", 2'd0, 2'b00, 32'd2);
    cycle(); rd_chk("p_count_t2", 2'd0, 2'b00, 32'd1);
    cycle();
    rd_chk("p_count_t3", 2'd0, 2'b00, 32'd3);
    rd_chk("p_done_t3", 2'd0, 2'b11, 32'd1);
    check_eq("p_irq_t3", {31'b0, counter_irq[0]}, 32'd0);
    check_eq("p_pwm_t3", {31'b0, pwm_out[0]}, 32'd1);
    cycle();
    rd_chk("p_count_t4", 2'd0, 2'b00, 32'd2);
    check_eq("p_irq_t4", {31'b0, counter_irq[0]}, 32'd1);
    check_eq("p_irq_any_t4", {31'b0, irq_any}, 32'd1);
    check_eq("p_pwm_t4", {31'b0, pwm_out[0]}, 32'd0);
    cycle(); rd_chk("p_count_t5", 2'd0, 2'b00, 32'd1);
    cycle(); rd_chk("p_count_t6", 2'd0, 2'b00, 32'd3);
    cycle(); cycle();
    tick = 4'b0000;
    rd_chk("p_count_at1", 2'd0, 2'b00, 32'd1);

    // Clear done, then reload write collides with terminal tick: write wins, no done.
    wr(2'd0, 2'b10, 32'h1E);
    rd_chk("c_done_cleared", 2'd0, 2'b11, 32'd0);
    tick = 4'b0001;
    wr(2'd0, 2'b00, 32'd10);
    tick = 4'b0000;
    rd_chk("c_wr_wins_count", 2'd0, 2'b00, 32'd10);
    rd_chk("c_wr_wins_done", 2'd0, 2'b11, 32'd0);
    check_eq("c_wr_wins_pwm", {31'b0, pwm_out[0]}, 32'd0);

    // Done-clear collides with terminal event: set wins, count untouched.
    wr(2'd0, 2'b00, 32'd1);
    tick = 4'b0001;
    wr(2'd0, 2'b10, 32'h1E);
    tick = 4'b0000;
    rd_chk("c_set_wins_done", 2'd0, 2'b11, 32'd1);
    rd_chk("c_ctl_drop_count", 2'd0, 2'b00, 32'd1);

    // Ch1 one-shot, reload 2, three ticks.
    wr(2'd1, 2'b00, 32'd2);
    wr(2'd1, 2'b10, 32'h5);
    tick = 4'b0010;
    cycle();
    rd_chk("o_count_t1", 2'd1, 2'b00, 32'd1);
    check_eq("o_pwm_t1", {31'b0, pwm_out[1]}, 32'd0);
    cycle();
    rd_chk("o_count_t2", 2'd1, 2'b00, 32'd0);
    rd_chk("o_ctrl_run_clr", 2'd1, 2'b10, 32'h1);
    rd_chk("o_status", 2'd1, 2'b11, 32'd1);
    check_eq("o_pwm_t2", {31'b0, pwm_out[1]}, 32'd1);
    cycle();
    tick = 4'b0000;
    rd_chk("o_count_t3", 2'd1, 2'b00, 32'd0);
    check_eq("o_pwm_t3", {31'b0, pwm_out[1]}, 32'd0);
    check_eq("o_irq", {31'b0, counter_irq[1]}, 32'd0);
    rd_chk("o_ch0_untouched", 2'd0, 2'b00, 32'd1);

    // Ch2 PWM, reload 4, compare 2 / 0 / 5.
    wr(2'd2, 2'b01, 32'd2);
    wr(2'd2, 2'b00, 32'd4);
    wr(2'd2, 2'b10, 32'h7);
    tick = 4'b0100;
    for (int k = 0; k < 4; k++) cycle();
    ones = 0;
    for (int k = 0; k < 8; k++) begin cycle(); ones += int'(pwm_out[2]); end
    check_eq("pwm_duty_2of4", 32'(ones), 32'd4);
    wr(2'd2, 2'b01, 32'd0);
    cycle(); cycle();
    ones = 0;
    for (int k = 0; k < 8; k++) begin cycle(); ones += int'(pwm_out[2]); end
    check_eq("pwm_cmp0", 32'(ones), 32'd0);
    wr(2'd2, 2'b01, 32'd5);
    cycle(); cycle();
    ones = 0;
    for (int k = 0; k < 8; k++) begin cycle(); ones += int'(pwm_out[2]); end
    check_eq("pwm_cmp5", 32'(ones), 32'd8);

    // Mid-count reset on ch0 at count 5.
    wr(2'd0, 2'b00, 32'd8);
    tick = 4'b0001;
    cycle(); cycle(); cycle();
    rd_chk("r_count5", 2'd0, 2'b00, 32'd5);
    check_eq("r_irq_before", {31'b0, counter_irq[0]}, 32'd1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    rd_chk("r_count_zero", 2'd0, 2'b00, 32'd0);
    rd_chk("r_done_zero", 2'd0, 2'b11, 32'd0);
    check_eq("r_irq", {28'b0, counter_irq}, 32'd0);
    check_eq("r_irq_any", {31'b0, irq_any}, 32'd0);
    check_eq("r_pwm", {28'b0, pwm_out}, 32'd0);
    tick = 4'hF;
    cycle(); cycle(); cycle();
    tick = 4'h0;
    rd_chk("r_no_count_ch0", 2'd0, 2'b00, 32'd0);
    rd_chk("r_no_count_ch2", 2'd2, 2'b00, 32'd0);
    check_eq("r_pwm_after", {28'b0, pwm_out}, 32'd0);

    // Three-channel, 8-bit instance.
    wr_b(2'd3, 2'b00, 32'h55);
    rd_chk_b("b_ch3_count", 2'd3, 2'b00, 32'd0);
    wr_b(2'd3, 2'b10, 32'hF);
    rd_chk_b("b_ch3_ctrl", 2'd3, 2'b10, 32'd0);
    rd_chk_b("b_ch2_ctrl", 2'd2, 2'b10, 32'd0);
    rd_chk_b("b_ch0_count", 2'd0, 2'b00, 32'd0);
    wr_b(2'd0, 2'b00, 32'h1FF);
    rd_chk_b("b_trunc_count", 2'd0, 2'b00, 32'hFF);
    wr_b(2'd1, 2'b01, 32'h1AB);
    rd_chk_b("b_trunc_cmp", 2'd1, 2'b01, 32'hAB);
    check_eq("b_irq", {29'b0, irq_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
